regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the 32-bit custom-ISA core. It is the next generation of the core's 16 x 32 register bank and is generalised in width, depth and read-port count. It adds an asynchronous active-low reset, a hardware clear sequencer, an optional hard-wired zero register, out-of-range address detection and optional write-to-read bypass. It sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- DATA_W, default 32: register width in bits.
- DEPTH, default 16: number of registers, any value ≥ 2.
- ADDR_W, default 8: address port width; must satisfy 2^ADDR_W ≥ DEPTH.
- N_RD, default 2: number of read ports, 1..4.
- R0_ZERO, default 0: when 1, register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- rd_en  in  1  read strobe, shared by all ports.
- rd_addr  in  N_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  N_RD*DATA_W  registered read data, packed the same way as rd_addr.
- rd_valid  out  1  rd_data was updated on this edge.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clr_req  in  1  one-cycle pulse that starts a full clear.
- busy  out  1  clear sequence in progress.
- err_oor  out  1  sticky flag: an out-of-range address was presented.

## Operation
- FSM has two states, CLEAR and IDLE.
  - Reset enters CLEAR with the clear counter at 0.
  - CLEAR writes 0 to entry clr_cnt each cycle and increments the counter. After entry DEPTH-1 is written, the FSM goes to IDLE.
  - In IDLE, clr_req=1 moves the FSM to CLEAR with clr_cnt=0.
  - clr_req while already in CLEAR is ignored; the sequence is not restarted.
- Writes are accepted only in IDLE. When wr_en=1 and wr_addr < DEPTH, entry wr_addr takes wr_data at the edge.
  - If wr_addr ≥ DEPTH, the write is dropped and err_oor is set.
  - If R0_ZERO=1 and wr_addr=0, the write is dropped silently; err_oor is not set.
- Reads are accepted only in IDLE. When rd_en=1, each port k registers the contents of entry rd_addr[k] and rd_valid pulses for 1 cycle.
  - An out-of-range port returns 0 and sets err_oor.
  - When R0_ZERO=1, address 0 returns 0.
  - When rd_en=0, or while busy, rd_data holds its previous value and rd_valid=0.
- err_oor stays set until reset or until a clear sequence completes. It is cleared on the edge that enters IDLE.
- The address-range check uses the full ADDR_W bits. Addresses are never truncated or wrapped.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=1, err_oor=0, FSM=CLEAR, clr_cnt=0.
- Array contents are undefined until the clear sequence finishes.
- A clear takes exactly DEPTH cycles.
  - busy is 1 from reset assertion, or from the edge after clr_req, until the edge on which entry DEPTH-1 is written. busy reads 0 on the following cycle.
- Read latency is 1 cycle: rd_data and rd_valid are valid after the edge that sampled rd_en.
- Simultaneous write and read of the same in-range address is governed by REGFILE_BYPASS_EN (see Configuration).
- Reset asserted mid-clear or mid-access aborts the operation immediately and restarts the clear sequence from entry 0.
- If clr_req and wr_en arrive in the same IDLE cycle, the write is performed first and the clear then overwrites it. The array ends all-zero.

## Configuration
- REGFILE_BYPASS_EN defined: a same-cycle write and read to the same address returns wr_data on rd_data. Bypass applies per port and never to register 0 when R0_ZERO=1.
- REGFILE_BYPASS_EN undefined: a same-cycle write and read returns the old contents (read-before-write). The new value is visible from the next read.

## Structure
- Package regfile_pkg holds:
  - the FSM state enum (ST_CLEAR, ST_IDLE);
  - localparam defaults for DATA_W, DEPTH, ADDR_W and N_RD;
  - a helper function that computes the clear-counter width, $clog2(DEPTH).
- One sub-module, regfile_clr_seq, contains the FSM, clr_cnt and busy. It outputs the clear write enable and clear address, which are muxed ahead of the array write port.
- The array itself and the read ports are inline in regfile_mp, using a generate loop over N_RD.

## Test plan
- Reset then idle: drop rst_n for 2 cycles, release → busy=1 for exactly 16 cycles. Then read all 16 entries on ports 0/1 → every value is 0.
- Write 0xDEADBEEF to r5, then next cycle rd_addr={5,5} with rd_en=1 → both ports show 0xDEADBEEF one cycle later and rd_valid pulses once.
- Same-cycle write 0x12345678 to r3 with a read of r3 (r3 previously 0xA) → 0x12345678 with REGFILE_BYPASS_EN defined, 0xA without it.
- Write and read at address 0x20 with DEPTH=16 → write dropped, rd_data=0, err_oor=1 and held. Then clr_req → err_oor=0 after 16 cycles.
- R0_ZERO=1: write 0xFFFFFFFF to r0 → a read returns 0 and err_oor stays 0.
- Pulse clr_req after writing r7=0x55; deassert rst_n at clear cycle 5 → sequence restarts, busy lasts 16 cycles after release, and r7 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
// The REGFILE_BYPASS_EN build option lives in regfile_mp.sv.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_N_RD   = 2;

  // Clear counter / array index width; never below one bit.
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry writing zero after reset or on clr_req,
// holding busy until the last entry has been written.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = cnt_w(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             busy,
  output logic [CNT_W-1:0] clr_addr,
  output logic             clr_last
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_addr == LAST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
          end
        end
        default: begin
          state    <= ST_CLEAR;
          busy     <= 1'b1;
          clr_addr <= '0;
        end
      endcase
    end
  end

  // Marks the edge that writes the final entry and returns to idle.
  assign clr_last = (state == ST_CLEAR) && (clr_addr == LAST);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with N_RD registered read ports and one write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_RD    = DEF_N_RD,
  parameter int R0_ZERO = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_en,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   clr_req,
  output logic                   busy,
  output logic                   err_oor
);

  localparam int CNT_W = cnt_w(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [CNT_W-1:0]  clr_addr;
  logic              clr_last;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_oor;
  logic              wr_r0;
  logic              wr_fire;
  logic              rd_fire;
  logic [N_RD-1:0]   rd_oor;
  logic              mem_we;
  logic [CNT_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              vld_p1;

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_last (clr_last)
  );

  assign wr_oor  = ({1'b0, wr_addr} >= DEPTH_A);
  assign wr_r0   = (R0_ZERO != 0) && (wr_addr == '0);
  assign wr_fire = !busy && wr_en && !wr_oor && !wr_r0;
  assign rd_fire = !busy && rd_en;

  // The clear sequencer owns the write port whenever busy.
  assign mem_we    = busy || wr_fire;
  assign mem_waddr = busy ? clr_addr : wr_addr[CNT_W-1:0];
  assign mem_wdata = busy ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              force_zero;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] data_p1;

    assign addr       = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_oor[k]  = ({1'b0, addr} >= DEPTH_A);
    assign force_zero = rd_oor[k] || ((R0_ZERO != 0) && (addr == '0));
`ifdef REGFILE_BYPASS_EN
    assign rdata = force_zero                      ? '0 :
                   (wr_fire && (wr_addr == addr))  ? wr_data :
                                                     mem[addr[CNT_W-1:0]];
`else
    assign rdata = force_zero ? '0 : mem[addr[CNT_W-1:0]];
`endif

    // Read stage boundary: one-cycle registered output per port.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       data_p1 <= '0;
      else if (rd_fire) data_p1 <= rdata;
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_p1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      err_oor <= 1'b0;
    end else begin
      vld_p1 <= rd_fire;
      if (clr_last)
        err_oor <= 1'b0;
      else if ((!busy && wr_en && wr_oor) || (rd_fire && (|rd_oor)))
        err_oor <= 1'b1;
    end
  end

  assign rd_valid = vld_p1;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboarded bench for regfile_mp: a default instance and an R0_ZERO=1 instance share stimulus.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rd_en = 1'b0;
  logic           wr_en = 1'b0;
  logic           clr_req = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [NR*DW-1:0] rd_data, rd_data_z;
  logic           rd_valid, rd_valid_z, busy, busy_z, err_oor, err_z;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] z0;
    logic [DW-1:0] z1;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  regfile_mp #(.DATA_W(DW), .DEPTH(16), .ADDR_W(AW), .N_RD(NR), .R0_ZERO(0)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .err_oor(err_oor)
  );

  regfile_mp #(.DATA_W(DW), .DEPTH(16), .ADDR_W(AW), .N_RD(NR), .R0_ZERO(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .rd_valid(rd_valid_z), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy_z), .err_oor(err_z)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Drives a read for the coming edge and queues what each instance should return.
  task automatic push_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    exp_t e;
    rd_en = 1'b1;
    rd_addr = {a1, a0};
    e.d0 = e0;
    e.d1 = e1;
    e.z0 = (a0 == '0) ? '0 : e0;
    e.z1 = (a1 == '0) ? '0 : e1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0 || err_oor !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b vld=%b data=%h err=%b want 1 0 0 0",
               busy, rd_valid, rd_data, err_oor);
    end
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++;
    if (n != 16) begin n_fail++; $display("FAIL reset_busy_len got %0d want 16", n); end
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      push_read(AW'(i), AW'(i + 8), '0, '0);
      tick();
      rd_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== {e.d1, e.d0} || rd_data_z !== {e.z1, e.z0}) begin
        n_fail++;
        $display("FAIL reset_read_%0d got vld=%b %h/%h want vld=1 %h/%h", i, rd_valid,
                 rd_data, rd_data_z, {e.d1, e.d0}, {e.z1, e.z0});
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    do_write(8'd5, 32'hDEADBEEF);
    push_read(8'd5, 8'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    tick();
    rd_en = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== {e.d1, e.d0}) begin
      n_fail++;
      $display("FAIL wr_rd_r5 got vld=%b %h want vld=1 %h", rd_valid, rd_data, {e.d1, e.d0});
    end
    tick();
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== {e.d1, e.d0}) begin
      n_fail++;
      $display("FAIL rd_hold got vld=%b %h want vld=0 %h", rd_valid, rd_data, {e.d1, e.d0});
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [DW-1:0] same;
`ifdef REGFILE_BYPASS_EN
    same = 32'h12345678;
`else
    same = 32'h0000000A;
`endif
    do_write(8'd3, 32'h0000000A);
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'h12345678;
    push_read(8'd3, 8'd5, same, 32'hDEADBEEF);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== {e.d1, e.d0}) begin
      n_fail++;
      $display("FAIL same_cycle_rw got %h want %h", rd_data, {e.d1, e.d0});
    end
    push_read(8'd3, 8'd3, 32'h12345678, 32'h12345678);
    tick();
    rd_en = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== {e.d1, e.d0}) begin
      n_fail++;
      $display("FAIL after_rw got %h want %h", rd_data, {e.d1, e.d0});
    end
  endtask

  task automatic test_oor();
    exp_t e;
    int   n;
    logic err_mid;
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 32'hCAFEF00D;
    push_read(8'h20, 8'd5, '0, 32'hDEADBEEF);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== {e.d1, e.d0} || err_oor !== 1'b1 || err_z !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_access got %h err=%b/%b want %h err=1/1", rd_data, err_oor, err_z,
               {e.d1, e.d0});
    end
    tick(); tick(); tick();
    n_cmp++;
    if (err_oor !== 1'b1) begin n_fail++; $display("FAIL oor_sticky got %b want 1", err_oor); end
    // A wrapped write would have landed in entry 0.
    push_read(8'd0, 8'h10, '0, '0);
    tick();
    rd_en = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== {e.d1, e.d0}) begin
      n_fail++;
      $display("FAIL oor_no_wrap got %h want %h", rd_data, {e.d1, e.d0});
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    err_mid = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 8) err_mid = err_oor;
      tick();
      n++;
    end
    n_cmp++;
    if (n != 16 || err_mid !== 1'b1 || err_oor !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_clear got len=%0d mid=%b end=%b want 16 1 0", n, err_mid, err_oor);
    end
  endtask

  task automatic test_r0_zero();
    exp_t e;
    do_write(8'd0, 32'hFFFFFFFF);
    push_read(8'd0, 8'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    rd_en = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_data_z !== {e.z1, e.z0} || rd_valid_z !== 1'b1 || err_z !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_zero got %h vld=%b err=%b want %h vld=1 err=0", rd_data_z, rd_valid_z,
               err_z, {e.z1, e.z0});
    end
    n_cmp++;
    if (rd_data !== {e.d1, e.d0} || err_oor !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_plain got %h err=%b want %h err=0", rd_data, err_oor, {e.d1, e.d0});
    end
  endtask

  task automatic test_clear_reset();
    exp_t e;
    int   n;
    do_write(8'd7, 32'h00000055);
    push_read(8'd7, 8'd7, 32'h55, 32'h55);
    tick();
    rd_en = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== {e.d1, e.d0}) begin
      n_fail++;
      $display("FAIL r7_write got %h want %h", rd_data, {e.d1, e.d0});
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_data !== '0 || busy !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midclear_reset got %h busy=%b vld=%b want 0 1 0", rd_data, busy, rd_valid);
    end
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++;
    if (n != 16) begin n_fail++; $display("FAIL restart_busy_len got %0d want 16", n); end
    push_read(8'd7, 8'd0, '0, '0);
    tick();
    rd_en = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== {e.d1, e.d0}) begin
      n_fail++;
      $display("FAIL r7_cleared got %h want %h", rd_data, {e.d1, e.d0});
    end
  endtask

  task automatic test_busy_clr_wr();
    exp_t e;
    int   m;
    do_write(8'd9, 32'h00000099);
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'h0000ABCD; clr_req = 1'b1;
    tick();
    wr_en = 1'b0; clr_req = 1'b0;
    rd_en = 1'b1; rd_addr = {8'd9, 8'd9};
    tick();
    rd_en = 1'b0;
    m = 1;
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_while_busy got vld=%b %h busy=%b want vld=0 0 busy=1", rd_valid,
               rd_data, busy);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    m++;
    while (busy === 1'b1 && m < 100) begin tick(); m++; end
    n_cmp++;
    if (m != 16) begin n_fail++; $display("FAIL clr_req_ignored got len=%0d want 16", m); end
    push_read(8'd9, 8'd9, '0, '0);
    tick();
    rd_en = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== {e.d1, e.d0}) begin
      n_fail++;
      $display("FAIL clr_over_wr got %h want %h", rd_data, {e.d1, e.d0});
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_oor();
    test_r0_zero();
    test_clear_reset();
    test_busy_clr_wr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
